pwm_sample_feeder: RTL and testbench

Upstream stage of the baseband PWM DAC output.
- Accepts signed IN_WIDTH-bit audio/baseband samples from the SoC datapath over a valid/ready handshake and buffers them in a small FIFO.
- Releases exactly one sample per PWM frame (2^OUT_WIDTH clocks), aligned to the PWM's free-running counter.
- Applies a Q1.7 gain, then rounds and saturates to the signed OUT_WIDTH-bit range the PWM expects (-512..511 for 10 bits).

---
 rtl/pwm_sample_feeder.sv | 180 ++++++++++++++++++
 tb/tb_pwm_sample_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_feeder.sv
// Sample feeder for the baseband PWM DAC. It buffers signed samples, applies a Q1.7 gain and
// releases one rounded, saturated sample per PWM frame. Optional error feedback: PWM_FEED_NOISE_SHAPE_EN.
module pwm_sample_feeder #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_in,
  input  logic                        rstn,
  input  logic                        feed_en,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [IN_WIDTH-1:0]         s_data,
  input  logic [7:0]                  gain,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        frame_tick,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  input  logic                        underrun_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = IN_WIDTH + 9;
  localparam int D  = IN_WIDTH - OUT_WIDTH;
  localparam int VW = IN_WIDTH + 1;

  localparam logic signed [PW-1:0] S_MAX = {{(PW-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] S_MIN = {{(PW-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [VW-1:0] Q_MAX = {{(VW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [VW-1:0] Q_MIN = {{(VW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [IN_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [IN_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                 underrun_q, underrun_d;

  logic wrap, push, pop, empty_pop;

  logic signed [PW-1:0]        head_ext, gain_ext, prod, prod_sh;
  logic signed [IN_WIDTH-1:0]  s_sat;
  logic        [D-1:0]         addend;
  logic signed [VW-1:0]        v, v_sh;
  logic                        sat;
  logic        [OUT_WIDTH-1:0] q_sat;

  // The pop point is the edge on which cnt wraps, shared in lockstep with the PWM counter.
  assign wrap      = (cnt_q == {OUT_WIDTH{1'b1}});
  assign s_ready   = rstn & feed_en & (level_q < LW'(FIFO_DEPTH));
  assign push      = s_valid & s_ready;
  assign pop       = wrap & feed_en & (level_q != '0);
  assign empty_pop = wrap & feed_en & (level_q == '0);

  always_comb begin
    cnt_d        = cnt_q + OUT_WIDTH'(1);
    frame_tick_d = (cnt_d == {OUT_WIDTH{1'b1}});
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (!feed_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Gain, rescale to IN_WIDTH, then drop D bits with the rounding or error-feedback addend.
  always_comb begin
    head_ext = {{(PW-IN_WIDTH){mem_q[rd_ptr_q][IN_WIDTH-1]}}, mem_q[rd_ptr_q]};
    gain_ext = {{(PW-8){1'b0}}, gain};
    prod     = head_ext * gain_ext;
    prod_sh  = prod >>> 7;
    if (prod_sh > S_MAX) begin
      s_sat = {1'b0, {(IN_WIDTH-1){1'b1}}};
    end else if (prod_sh < S_MIN) begin
      s_sat = {1'b1, {(IN_WIDTH-1){1'b0}}};
    end else begin
      s_sat = prod_sh[IN_WIDTH-1:0];
    end
    v    = {s_sat[IN_WIDTH-1], s_sat} + {{(VW-D){1'b0}}, addend};
    v_sh = v >>> D;
    sat  = 1'b0;
    if (v_sh > Q_MAX) begin
      q_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat   = 1'b1;
    end else if (v_sh < Q_MIN) begin
      q_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat   = 1'b1;
    end else begin
      q_sat = v_sh[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    underrun_d = underrun_q;
    if (!feed_en) begin
      data_out_d = '0;
    end else if (pop) begin
      data_out_d = q_sat;
    end
    if (underrun_clr) underrun_d = 1'b0;
    if (empty_pop)    underrun_d = 1'b1;
  end

`ifdef PWM_FEED_NOISE_SHAPE_EN
  logic [D-1:0] err_q, err_d;

  // The residual carries only across real pops; a saturated result discards it.
  always_comb begin
    err_d = err_q;
    if (!feed_en) begin
      err_d = '0;
    end else if (pop) begin
      err_d = sat ? '0 : v[D-1:0];
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) err_q <= '0;
    else       err_q <= err_d;
  end

  assign addend = err_q;
`else
  localparam logic [D-1:0] HALF = D'(1 << (D-1));
  assign addend = HALF;
`endif

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      underrun_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign data_out   = data_out_q;
  assign frame_tick = frame_tick_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder: reset, timing, rounding, saturation, FIFO flow,
// underrun, disable, mid-run reset and the PWM_FEED_NOISE_SHAPE_EN residual sequence.
`timescale 1ns/1ps
module tb_pwm_sample_feeder;
  logic        clk_in = 1'b0;
  logic        rstn;
  logic        feed_en;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [7:0]  gain;
  logic [9:0]  data_out;
  logic        frame_tick;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic        underrun_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  pwm_sample_feeder #(.IN_WIDTH(16), .OUT_WIDTH(10), .FIFO_DEPTH(8)) dut (
    .clk_in(clk_in), .rstn(rstn), .feed_en(feed_en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .gain(gain), .data_out(data_out), .frame_tick(frame_tick),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    if (frame_tick !== 1'b1) begin
      tests++; fails++;
      $display("[TB] FAIL frame_tick_timeout: frame_tick=%b, required 1 within 1100 cycles", frame_tick);
    end
  endtask

  task automatic wait_pop();
    wait_tick();
    step();
  endtask

  task automatic push(input logic [15:0] v);
    s_valid = 1'b1;
    s_data  = v;
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; feed_en = 1'b1; s_valid = 1'b0; s_data = '0; gain = 8'd128; underrun_clr = 1'b0;
    step(); step();
    tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_s_ready: got %b, required 0", s_ready); end
    tests++; if (data_out !== 10'd0) begin fails++; $display("[TB] FAIL reset_data_out: got %0d, required 0", data_out); end
    tests++; if (frame_tick !== 1'b0 || underrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags: frame_tick=%b underrun=%b, required 0 0", frame_tick, underrun); end
    tests++; if (fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL reset_level: got %0d, required 0", fifo_level); end
    rstn = 1'b1;
    #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL ready_after_reset: got %b, required 1", s_ready); end
  endtask

  task automatic test_basic();
    int cycles;
    int bad;
    push(16'h4000);
    cycles = 1;
    tests++; if (fifo_level !== 4'd1) begin fails++; $display("[TB] FAIL basic_level: got %0d, required 1", fifo_level); end
    while (frame_tick !== 1'b1 && cycles < 1100) begin
      step();
      cycles++;
    end
    tests++; if (cycles !== 1023) begin fails++; $display("[TB] FAIL first_tick: after %0d cycles, required 1023", cycles); end
    tests++; if (data_out !== 10'd0) begin fails++; $display("[TB] FAIL basic_pre_pop: got %0d, required 0", $signed(data_out)); end
    step();
    tests++; if ($signed(data_out) !== 256) begin fails++; $display("[TB] FAIL basic_data: got %0d, required 256", $signed(data_out)); end
    tests++; if (fifo_level !== 4'd0 || underrun !== 1'b0) begin fails++; $display("[TB] FAIL basic_after_pop: level=%0d underrun=%b, required 0 0", fifo_level, underrun); end
    bad = 0;
    for (int i = 0; i < 1023; i++) begin
      step();
      if ($signed(data_out) !== 256) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("[TB] FAIL basic_stable: %0d cycles changed, required 0", bad); end
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("[TB] FAIL frame_period: frame_tick=%b at cnt 1023, required 1", frame_tick); end
  endtask

  task automatic test_rounding();
    int rin[4] = '{32, 31, -32, -33};
`ifdef PWM_FEED_NOISE_SHAPE_EN
    int rexp[4] = '{0, 0, 0, -1};
`else
    int rexp[4] = '{1, 0, 0, -1};
`endif
    gain = 8'd128;
    for (int i = 0; i < 4; i++) push(16'(rin[i]));
    for (int i = 0; i < 4; i++) begin
      wait_pop();
      tests++; if ($signed(data_out) !== rexp[i]) begin fails++; $display("[TB] FAIL rounding[%0d]: got %0d, required %0d", i, $signed(data_out), rexp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] sin[4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'hC000};
    logic [7:0]  sg[4]  = '{8'd255, 8'd255, 8'd128, 8'd64};
    int          sexp[4] = '{511, -512, -512, -128};
    for (int i = 0; i < 4; i++) push(sin[i]);
    for (int i = 0; i < 4; i++) begin
      gain = sg[i];
      wait_pop();
      tests++; if ($signed(data_out) !== sexp[i]) begin fails++; $display("[TB] FAIL saturation[%0d]: got %0d, required %0d", i, $signed(data_out), sexp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    gain = 8'd128;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (s_ready !== 1'b1) bad++;
      push(16'(k * 64));
    end
    tests++; if (bad != 0) begin fails++; $display("[TB] FAIL ready_while_filling: %0d pushes refused, required 0", bad); end
    tests++; if (fifo_level !== 4'd8 || s_ready !== 1'b0) begin fails++; $display("[TB] FAIL full: level=%0d s_ready=%b, required 8 0", fifo_level, s_ready); end
    s_valid = 1'b1;
    s_data  = 16'(9 * 64);
    wait_pop();
    tests++; if ($signed(data_out) !== 1 || fifo_level !== 4'd7 || s_ready !== 1'b1) begin fails++; $display("[TB] FAIL pop_from_full: data=%0d level=%0d s_ready=%b, required 1 7 1", $signed(data_out), fifo_level, s_ready); end
    step();
    s_valid = 1'b0;
    tests++; if (fifo_level !== 4'd8) begin fails++; $display("[TB] FAIL held_push: level=%0d, required 8", fifo_level); end
    wait_pop();
    tests++; if ($signed(data_out) !== 2 || fifo_level !== 4'd7) begin fails++; $display("[TB] FAIL second_pop: data=%0d level=%0d, required 2 7", $signed(data_out), fifo_level); end
    wait_tick();
    s_valid = 1'b1;
    s_data  = 16'(10 * 64);
    step();
    s_valid = 1'b0;
    tests++; if ($signed(data_out) !== 3 || fifo_level !== 4'd7) begin fails++; $display("[TB] FAIL push_pop_same_edge: data=%0d level=%0d, required 3 7", $signed(data_out), fifo_level); end
    bad = 0;
    for (int k = 4; k <= 10; k++) begin
      wait_pop();
      if ($signed(data_out) !== k) bad++;
    end
    tests++; if (bad != 0 || fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL fifo_order: %0d wrong pops level=%0d, required 0 0", bad, fifo_level); end
  endtask

  task automatic test_underrun();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    tests++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL clear: underrun=%b, required 0", underrun); end
    wait_pop();
    tests++; if ($signed(data_out) !== 10 || underrun !== 1'b1 || fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL underrun_hold: data=%0d underrun=%b level=%0d, required 10 1 0", $signed(data_out), underrun, fifo_level); end
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    tests++; if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL clear_after_underrun: underrun=%b, required 0", underrun); end
    wait_tick();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    tests++; if (underrun !== 1'b1) begin fails++; $display("[TB] FAIL clear_vs_set: underrun=%b, required 1", underrun); end
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    push(16'(5 * 64));
    tests++; if (fifo_level !== 4'd1) begin fails++; $display("[TB] FAIL pre_disable_level: got %0d, required 1", fifo_level); end
    feed_en = 1'b0;
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("[TB] FAIL disabled_ready: got %b, required 0", s_ready); end
    step();
    tests++; if (data_out !== 10'd0 || fifo_level !== 4'd0) begin fails++; $display("[TB] FAIL disable_flush: data=%0d level=%0d, required 0 0", $signed(data_out), fifo_level); end
    wait_pop();
    tests++; if (underrun !== 1'b0 || data_out !== 10'd0) begin fails++; $display("[TB] FAIL disabled_frame: underrun=%b data=%0d, required 0 0", underrun, $signed(data_out)); end
    feed_en = 1'b1;
    push(16'(6 * 64));
    wait_pop();
    tests++; if ($signed(data_out) !== 6) begin fails++; $display("[TB] FAIL flushed_sample_gone: got %0d, required 6", $signed(data_out)); end
  endtask

  task automatic test_reset_mid();
    push(16'(7 * 64));
    tests++; if (fifo_level !== 4'd1) begin fails++; $display("[TB] FAIL mid_level: got %0d, required 1", fifo_level); end
    #2;
    rstn = 1'b0;
    #1;
    tests++; if (data_out !== 10'd0 || fifo_level !== 4'd0 || s_ready !== 1'b0 || frame_tick !== 1'b0) begin fails++; $display("[TB] FAIL async_reset: data=%0d level=%0d s_ready=%b tick=%b, required 0 0 0 0", $signed(data_out), fifo_level, s_ready, frame_tick); end
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_noise_shape();
`ifdef PWM_FEED_NOISE_SHAPE_EN
    int nexp[4] = '{0, 0, 0, 1};
`else
    int nexp[4] = '{0, 0, 0, 0};
`endif
    gain = 8'd128;
    for (int i = 0; i < 8; i++) push(16'd16);
    for (int i = 0; i < 8; i++) begin
      wait_pop();
      tests++; if ($signed(data_out) !== nexp[i % 4]) begin fails++; $display("[TB] FAIL noise_shape[%0d]: got %0d, required %0d", i, $signed(data_out), nexp[i % 4]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_noise_shape();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
